axi_burst_wr_master: RTL and testbench
======================================

Name: axi_burst_wr_master

Overview:
User-side write front end for the DDR2 controller. It accepts one write request (start address, length in beats) and splits it into AXI write bursts of at most WBURST_LEN beats. It drives the AW, W and B channels into the controller's slave port. Write data is pulled from the user one beat per AXI handshake.

Parameters:
ADDR_WIDTH, 27, byte/column address width (row+col+bank)
DATA_WIDTH, 16, AXI data beat width
DATA_LEVEL, 2, address increment per beat (columns per beat)
WBURST_LEN, 8, maximum beats per AXI write burst (1..256)
RBURST_LEN, 8, unused here; kept for interface parity with the read master

Ports:
clk  in  1  system clock
rstn  in  1  synchronous, active-high reset (1 = reset, despite the name)
init_end  in  1  DDR2 initialisation complete; no request accepted while low
axi_awvalid  out  1  write address valid
axi_awready  in  1  write address ready
axi_awaddr  out  ADDR_WIDTH  burst start address
axi_awlen  out  8  beats in burst minus 1
axi_wvalid  out  1  write data valid
axi_wready  in  1  write data ready
axi_wlast  out  1  last beat of burst
axi_wdata  out  DATA_WIDTH  write data (= wr_data)
axi_bvalid  in  1  write response valid
axi_bready  out  1  write response ready
wr_trig  in  1  request; held by the user until wr_ready seen
wr_len  in  8  request length in beats
wr_data  in  DATA_WIDTH  current beat data from user
wr_data_en  out  1  beat consumed; user advances wr_data next cycle
wr_addr  in  ADDR_WIDTH  request start address
wr_ready  out  1  master idle and able to accept
wr_done  out  1  one-cycle pulse when the whole request has completed

Behaviour:
- Reset (rstn=1 at clk edge): state IDLE. awvalid, wvalid, wlast, bready, wr_done and wr_ready are 0. awaddr, awlen, remaining and beat counters are 0.
- FSM states: IDLE, AW, W, B.
- IDLE:
  - wr_ready = init_end (registered or combinational, but 0 in reset).
  - Accept when wr_trig & wr_ready. On accept, latch cur_addr=wr_addr and remaining=wr_len, then go to AW.
  - wr_len=0: no bursts; pulse wr_done the next cycle and stay IDLE.
- AW:
  - axi_awvalid=1.
  - axi_awaddr=cur_addr.
  - axi_awlen = min(remaining, WBURST_LEN) - 1.
  - Hold all values until axi_awready. On the handshake, drop awvalid, set beat counter to 0 and go to W.
- W:
  - axi_wvalid=1.
  - axi_wdata=wr_data (combinational pass-through).
  - axi_wlast=1 when beat counter == awlen.
  - wr_data_en = axi_wvalid & axi_wready (combinational). The beat counter increments on each handshake.
  - On a handshake with wlast, go to B.
  - wvalid is never dropped mid-burst by the master.
- B:
  - axi_bready=1.
  - On axi_bvalid:
    - remaining -= burst_beats.
    - cur_addr += burst_beats*DATA_LEVEL.
  - If the new remaining is 0: pulse wr_done for exactly 1 cycle and go to IDLE. Otherwise go back to AW.
- Only one burst is outstanding at a time; AW for the next burst is issued only after B of the previous one.
- Final partial burst uses the residue, e.g. wr_len=20 with WBURST_LEN=8 gives bursts of 8, 8, 4.
- wr_trig is ignored outside IDLE. wr_ready stays 0 from accept until the cycle after the wr_done pulse.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Lengths are unsigned 8-bit.
- Reset asserted mid-transfer aborts immediately to IDLE with all outputs at reset values. No outstanding-handshake recovery is required.

Decomposition:
- Shared package: FSM state encoding (IDLE/AW/W/B), and ADDR_WIDTH / DATA_WIDTH / DATA_LEVEL / burst-length defaults shared with the read master and ddr2_ctrl.
- Single module. No sub-module needed; the burst-size computation can be a local function.

Test Plan:
1. Reset, then init_end=0 with wr_trig=1 -> wr_ready=0, no awvalid. Raise init_end -> wr_ready=1, request accepted next edge.
2. wr_addr=0, wr_len=72, slave always ready, wr_data starting at 1 incremented on wr_data_en:
   - 9 bursts, awlen=7 each.
   - awaddr = 0, 16, 32 … 128.
   - wdata 1..72 in order; wlast on beats 8, 16 … 72.
   - Exactly one wr_done pulse after the 9th bvalid.
3. wr_len=20 -> awlen 7, 7, 3; awaddr 0, 16, 32; 20 wr_data_en pulses.
4. Random backpressure on awready/wready/bvalid -> awaddr/awlen/wdata stable while valid & !ready, and no beat lost or duplicated.
5. Back-to-back requests: re-trigger on wr_done with wr_addr += 144 -> second transfer starts at 144. wr_trig during a transfer is ignored.
6. Reset asserted mid-W-burst -> next cycle all valids 0, state IDLE, wr_ready=init_end after reset release.

Source files
------------

// File: rtl/axi_burst_wr_master_pkg.sv
// Shared definitions for the DDR2 AXI user-side masters.
// Contents: the write-master FSM state encoding, and the default address,
// data and burst geometry. The read master and ddr2_ctrl use the same
// defaults.
package axi_burst_wr_master_pkg;

  localparam int DEF_ADDR_WIDTH = 27;  // row + col + bank
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DATA_LEVEL = 2;   // columns advanced per beat
  localparam int DEF_WBURST_LEN = 8;
  localparam int DEF_RBURST_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

endpackage

// File: rtl/axi_burst_wr_master.sv
// axi_burst_wr_master
// This is the user-side write front end for the DDR2 controller. It takes
// one request (start address, length in beats) and splits it into AXI write
// bursts of at most WBURST_LEN beats. It keeps one burst outstanding at a time.
// The user supplies write data one beat per W handshake.
//
// Ports
//   clk, rstn      clock; synchronous reset, active HIGH (despite the name)
//   init_end       DDR2 init complete; gates wr_ready
//   axi_aw*        write address channel (awvalid/awready/awaddr/awlen)
//   axi_w*         write data channel (wvalid/wready/wlast/wdata)
//   axi_b*         write response channel (bvalid/bready)
//   wr_trig        user request, held until accepted
//   wr_addr/len    request start address / length in beats
//   wr_data        current user beat, passed straight to axi_wdata
//   wr_data_en     beat consumed; the user advances wr_data next cycle
//   wr_ready       idle and able to accept a request
//   wr_done        one-cycle pulse when the whole request has finished
module axi_burst_wr_master
  import axi_burst_wr_master_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_LEVEL = DEF_DATA_LEVEL,
  parameter int WBURST_LEN = DEF_WBURST_LEN,
  parameter int RBURST_LEN = DEF_RBURST_LEN   // interface parity with read master
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  init_end,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic                  axi_wlast,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic                  wr_trig,
  input  logic [7:0]            wr_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_ready,
  output logic                  wr_done
);

  localparam logic [8:0] WB_MAX = 9'(WBURST_LEN);

  // Size of the next burst: whatever is left, capped at WBURST_LEN.
  function automatic logic [8:0] burst_beats(input logic [7:0] rem);
    if ({1'b0, rem} > WB_MAX) return WB_MAX;
    return {1'b0, rem};
  endfunction

  wr_state_e             state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [7:0]            remaining;
  logic [7:0]            beat_cnt;

  logic [8:0]            cur_beats;   // beats in the burst now in flight
  logic [7:0]            rem_nxt;
  logic [8:0]            nxt_beats;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  // The in-flight burst length comes back out of awlen, so no separate
  // register is needed. The remaining count is at most 255, so cur_beats
  // never reaches 256 and its low byte is exact.
  assign cur_beats = {1'b0, axi_awlen} + 9'd1;
  assign rem_nxt   = remaining - cur_beats[7:0];
  assign nxt_beats = burst_beats(rem_nxt);
  assign addr_nxt  = cur_addr + ADDR_WIDTH'(cur_beats * DATA_LEVEL);

  assign axi_wdata  = wr_data;
  assign wr_data_en = axi_wvalid & axi_wready;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state       <= ST_IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      beat_cnt    <= '0;
      axi_awvalid <= 1'b0;
      axi_awaddr  <= '0;
      axi_awlen   <= '0;
      axi_wvalid  <= 1'b0;
      axi_wlast   <= 1'b0;
      axi_bready  <= 1'b0;
      wr_ready    <= 1'b0;
      wr_done     <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_trig && wr_ready) begin
            wr_ready  <= 1'b0;
            cur_addr  <= wr_addr;
            remaining <= wr_len;
            if (wr_len == 8'd0) begin
              wr_done <= 1'b1;
            end else begin
              state       <= ST_AW;
              axi_awvalid <= 1'b1;
              axi_awaddr  <= wr_addr;
              axi_awlen   <= 8'(burst_beats(wr_len) - 9'd1);
            end
          end else begin
            // During the wr_done pulse cycle wr_ready is still 0. It rises
            // on the following edge.
            wr_ready <= init_end;
          end
        end
        ST_AW: begin
          if (axi_awready) begin
            axi_awvalid <= 1'b0;
            beat_cnt    <= '0;
            axi_wvalid  <= 1'b1;
            axi_wlast   <= (axi_awlen == 8'd0);
            state       <= ST_W;
          end
        end
        ST_W: begin
          if (axi_wready) begin
            beat_cnt  <= beat_cnt + 8'd1;
            axi_wlast <= (8'(beat_cnt + 8'd1) == axi_awlen);
            if (axi_wlast) begin
              axi_wvalid <= 1'b0;
              axi_wlast  <= 1'b0;
              axi_bready <= 1'b1;
              state      <= ST_B;
            end
          end
        end
        ST_B: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            remaining  <= rem_nxt;
            cur_addr   <= addr_nxt;
            if (rem_nxt == 8'd0) begin
              wr_done <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              state       <= ST_AW;
              axi_awvalid <= 1'b1;
              axi_awaddr  <= addr_nxt;
              axi_awlen   <= 8'(nxt_beats - 9'd1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_wr_master.sv
// Directed bench for axi_burst_wr_master. The bench acts as the AXI slave
// and as the user. Inputs change on the falling edge. Outputs are sampled
// 1 time unit later, while valid/ready are stable ahead of the rising edge
// where a handshake completes.
module tb_axi_burst_wr_master;

  logic        clk, rstn, init_end;
  logic        axi_awvalid, axi_awready;
  logic [26:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic        axi_wvalid, axi_wready, axi_wlast;
  logic [15:0] axi_wdata;
  logic        axi_bvalid, axi_bready;
  logic        wr_trig;
  logic [7:0]  wr_len;
  logic [15:0] wr_data;
  logic        wr_data_en;
  logic [26:0] wr_addr;
  logic        wr_ready, wr_done;

  int n_tests = 0;
  int n_fail  = 0;

  axi_burst_wr_master dut (
    .clk(clk), .rstn(rstn), .init_end(init_end),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wlast(axi_wlast), .axi_wdata(axi_wdata),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .wr_trig(wr_trig), .wr_len(wr_len), .wr_data(wr_data),
    .wr_data_en(wr_data_en), .wr_addr(wr_addr),
    .wr_ready(wr_ready), .wr_done(wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_awvalid"}, axi_awvalid, 0);
    chk({tag, "_wvalid"},  axi_wvalid,  0);
    chk({tag, "_wlast"},   axi_wlast,   0);
    chk({tag, "_bready"},  axi_bready,  0);
    chk({tag, "_done"},    wr_done,     0);
    chk({tag, "_awaddr"},  axi_awaddr,  0);
    chk({tag, "_awlen"},   axi_awlen,   0);
  endtask

  // Run one request through to wr_done. Expected bursts come from a simple
  // model: each burst is min(remaining, 8) beats, and the address advances
  // by 2 per beat, modulo 2^27. The user data ramps from d0.
  task automatic do_xfer(input logic [26:0] addr, input logic [7:0] len,
                         input bit bp, input bit spam, input logic [15:0] d0);
    logic [26:0] ea, h_addr;
    logic [7:0]  rem, bl, beat, h_len;
    logic [15:0] ed;
    int nb, nen, ndone, cyc, post, exp_nb;
    bit bpend, hs_w, aw_stall;
    ea = addr; rem = len; bl = 8'd1; beat = 0; ed = d0;
    nb = 0; nen = 0; ndone = 0; post = -1;
    bpend = 0; hs_w = 0; aw_stall = 0; h_addr = '0; h_len = '0;
    exp_nb = (int'(len) + 7) / 8;
    wr_data = d0;
    cyc = 0;
    while (!wr_ready && cyc < 50) begin @(negedge clk); cyc++; end
    chk("ready_before_req", wr_ready, 1);
    wr_addr = addr; wr_len = len; wr_trig = 1'b1;
    @(posedge clk); @(negedge clk);
    wr_trig = spam;
    if (spam) begin wr_addr = 27'h1234; wr_len = 8'd5; end
    chk("ready_low_after_accept", wr_ready, 0);
    cyc = 0;
    while (post != 0 && cyc < 3000) begin
      if (hs_w) wr_data = wr_data + 16'd1;
      axi_awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_bvalid  = bpend && (bp ? 1'($urandom_range(0, 1)) : 1'b1);
      #1;
      hs_w = 0;
      if (aw_stall) begin
        chk("aw_valid_held", axi_awvalid, 1);
        chk("aw_addr_stable", axi_awaddr, h_addr);
        chk("aw_len_stable", axi_awlen, h_len);
      end
      aw_stall = axi_awvalid && !axi_awready;
      h_addr = axi_awaddr; h_len = axi_awlen;
      if (axi_awvalid && axi_awready) begin
        bl = (rem > 8'd8) ? 8'd8 : rem;
        chk("awaddr", axi_awaddr, ea);
        chk("awlen", axi_awlen, bl - 8'd1);
        beat = 0; nb++;
      end
      if (axi_wvalid) begin
        chk("wdata", axi_wdata, ed);
        chk("wlast", axi_wlast, beat == bl - 8'd1);
        chk("wr_data_en", wr_data_en, axi_wready);
        if (axi_wready) begin
          hs_w = 1; ed++; nen++;
          if (beat == bl - 8'd1) bpend = 1;
          beat++;
        end
      end else begin
        chk("wr_data_en_idle", wr_data_en, 0);
      end
      if (axi_bvalid && axi_bready) begin
        bpend = 0; rem = rem - bl; ea = ea + 27'(bl) * 27'd2;
      end
      if (wr_done) begin
        ndone++; wr_trig = 1'b0;
        if (post < 0) begin post = 3; chk("ready_during_done", wr_ready, 0); end
      end
      if (post > 0) post--;
      @(negedge clk); cyc++;
    end
    chk("xfer_timeout", cyc < 3000, 1);
    chk("burst_count", nb, exp_nb);
    chk("beat_count", nen, len);
    chk("done_pulses", ndone, 1);
    chk("remaining_zero", rem, 0);
    chk("ready_after_done", wr_ready, 1);
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; wr_trig = 0;
  endtask

  initial begin
    int n;
    rstn = 1; init_end = 0; wr_trig = 0; wr_len = 0; wr_addr = 0; wr_data = 0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_ready", wr_ready, 0);
    chk_idle_outputs("rst");

    // No accept while init_end is low. Then a zero-length request.
    rstn = 0; wr_trig = 1; wr_len = 0; wr_addr = 27'h40;
    repeat (4) begin
      @(negedge clk);
      chk("pre_init_ready", wr_ready, 0);
      chk("pre_init_awvalid", axi_awvalid, 0);
    end
    init_end = 1;
    @(negedge clk);
    chk("init_ready", wr_ready, 1);
    @(negedge clk);
    chk("len0_done", wr_done, 1);
    chk("len0_ready", wr_ready, 0);
    chk("len0_awvalid", axi_awvalid, 0);
    wr_trig = 0;
    @(negedge clk);
    chk("len0_done_clear", wr_done, 0);
    chk("len0_ready_back", wr_ready, 1);

    do_xfer(27'd0, 8'd72, 0, 0, 16'd1);          // 9 full bursts
    do_xfer(27'd0, 8'd20, 0, 0, 16'h100);        // 8, 8, 4
    do_xfer(27'h100, 8'd50, 1, 0, 16'h2000);     // random backpressure
    do_xfer(27'd0, 8'd72, 0, 1, 16'd1);          // trig spam ignored
    do_xfer(27'd144, 8'd20, 1, 1, 16'h300);      // back-to-back follow-up
    do_xfer(27'h7FFFFF8, 8'd10, 0, 0, 16'h50);   // address wraps to 8

    // Reset in the middle of a W burst.
    n = 0;
    wr_addr = 27'h80; wr_len = 8'd20; wr_trig = 1;
    axi_awready = 1; axi_wready = 1;
    @(negedge clk);
    wr_trig = 0;
    for (int c = 0; c < 50 && n < 3; c++) begin
      @(negedge clk);
      if (axi_wvalid && axi_wready) n++;
    end
    chk("midw_beats", n, 3);
    chk("midw_wvalid", axi_wvalid, 1);
    rstn = 1;
    @(negedge clk);
    chk("midw_rst_ready", wr_ready, 0);
    chk_idle_outputs("midw_rst");
    rstn = 0; axi_awready = 0; axi_wready = 0;
    @(negedge clk);
    chk("midw_ready_back", wr_ready, 1);
    chk("midw_awvalid_idle", axi_awvalid, 0);

    do_xfer(27'd5, 8'd3, 0, 0, 16'h7);           // recovery, single short burst

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
